// File: rtl/fp_mult_pipe_hs_pkg.sv
// Shared definitions for the pipelined floating-point multiplier:
// operand class bits, exception flag layout, rounding-mode codes and the
// operand classification helper. No ports (package).
package fp_mult_pipe_hs_pkg;

  // Rounding-mode codes carried alongside each operand pair.
  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  // Per-operand class bits. Subnormals are reported as zero.
  typedef struct packed {
    logic zero;
    logic inf;
    logic qnan;
    logic snan;
  } fp_cls_t;

  // Exception flags in output order {invalid, overflow, underflow, inexact}.
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Classify an operand from its exponent/fraction summary bits.
  function automatic fp_cls_t classify(input logic exp_ones, input logic exp_zero,
                                       input logic frac_msb, input logic frac_nz);
    fp_cls_t c;
    c.zero = exp_zero;
    c.inf  = exp_ones && !frac_nz;
    c.qnan = exp_ones && frac_msb;
    c.snan = exp_ones && !frac_msb && frac_nz;
    return c;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_hs_if.sv
// Handshake bundle for the floating-point multiplier.
//   in_valid/in_ready : operand-side handshake; a, b, rnd_mode travel together
//   out_valid/out_ready : result-side handshake; out and flags travel together
// Modports: master = producer of operands / consumer of results,
//           slave  = the multiplier itself.
interface fp_mult_pipe_hs_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp_mult_pipe_hs_round.sv
// fp_mul_round: combinational normalise + guard/sticky + round increment.
// Ports:
//   prod_i    : raw (MAN_W+1)x(MAN_W+1) mantissa product, value in [1,4)
//   exp_i     : biased, signed exponent before normalisation
//   rne_i     : 1 = round-nearest-even, 0 = truncate
//   frac_o    : rounded stored fraction (hidden bit dropped)
//   exp_o     : exponent after normalisation and rounding carry
//   inexact_o : any discarded bit was non-zero
module fp_mul_round #(
  parameter int MAN_W = 23,
  parameter int EW    = 10
) (
  input  logic [2*MAN_W+1:0]   prod_i,
  input  logic signed [EW-1:0] exp_i,
  input  logic                 rne_i,
  output logic [MAN_W-1:0]     frac_o,
  output logic signed [EW-1:0] exp_o,
  output logic                 inexact_o
);
  localparam logic signed [EW-1:0] ONE = EW'(1);

  logic [MAN_W-1:0]     frac_n;
  logic                 g;
  logic                 s;
  logic signed [EW-1:0] exp_n;
  logic                 inc;
  logic                 carry;
  logic [MAN_W-1:0]     frac_r;

  always_comb begin
    if (prod_i[2*MAN_W+1]) begin
      // Product in [2,4): leading one sits one place higher.
      frac_n = prod_i[2*MAN_W:MAN_W+1];
      g      = prod_i[MAN_W];
      s      = |prod_i[MAN_W-1:0];
      exp_n  = exp_i + ONE;
    end else begin
      frac_n = prod_i[2*MAN_W-1:MAN_W];
      g      = prod_i[MAN_W-1];
      s      = |prod_i[MAN_W-2:0];
      exp_n  = exp_i;
    end
  end

  assign inc = rne_i && g && (s || frac_n[0]);

  // A carry out of the fraction leaves it all-zero, which is exactly 1.0
  // at the next exponent, so only the exponent needs correcting.
  assign {carry, frac_r} = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};

  assign frac_o    = frac_r;
  assign exp_o     = carry ? exp_n + ONE : exp_n;
  assign inexact_o = g | s;

endmodule

// File: rtl/fp_mult_pipe_hs.sv
// fp_mult_pipe_hs: 4-stage IEEE-754 binary multiplier with valid/ready
// handshake. Stages: unpack -> multiply -> normalise/round -> pack.
// A stalled output (out_valid && !out_ready) freezes every stage.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset, discards in-flight operations
//   bus : fp_mult_pipe_hs_if.slave (operands, rnd_mode, result, flags)
module fp_mult_pipe_hs
  import fp_mult_pipe_hs_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_mult_pipe_hs_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int EW     = EXP_W + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX_I);
  localparam logic signed [EW-1:0] EZERO  = '0;

  // Result packing with NaN/inf/zero precedence and exponent saturation.
  function automatic logic [W+3:0] pack_result(
    input logic                 sgn,
    input fp_cls_t              ca,
    input fp_cls_t              cb,
    input logic [MAN_W-1:0]     frac,
    input logic signed [EW-1:0] exp,
    input logic                 inx,
    input logic                 rnd
  );
    fp_flags_t    fl;
    logic [W-1:0] res;
    logic         inf_zero;
    inf_zero = (ca.inf && cb.zero) || (ca.zero && cb.inf);
    fl = '0;
    if (ca.qnan || ca.snan || cb.qnan || cb.snan || inf_zero) begin
      res        = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      fl.invalid = inf_zero || ca.snan || cb.snan;
    end else if (ca.inf || cb.inf) begin
      res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca.zero || cb.zero) begin
      res = {sgn, {(W-1){1'b0}}};
    end else if (exp >= EMAX_S) begin
      fl.overflow = 1'b1;
      fl.inexact  = 1'b1;
      if (rnd == RND_RTZ)
        res = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp <= EZERO) begin
      res          = {sgn, {(W-1){1'b0}}};
      fl.underflow = 1'b1;
      fl.inexact   = 1'b1;
    end else begin
      res        = {sgn, exp[EXP_W-1:0], frac};
      fl.inexact = inx;
    end
    return {fl, res};
  endfunction

  logic stall;
  logic en;

  logic                 vld_p1_q, sgn_p1_q, rnd_p1_q;
  fp_cls_t              cls_a_p1_q, cls_b_p1_q;
  logic [MAN_W:0]       man_a_p1_q, man_b_p1_q;
  logic signed [EW-1:0] exp_p1_q;

  logic                 vld_p2_q, sgn_p2_q, rnd_p2_q;
  fp_cls_t              cls_a_p2_q, cls_b_p2_q;
  logic [PW-1:0]        prod_p2_q;
  logic signed [EW-1:0] exp_p2_q;

  logic                 vld_p3_q, sgn_p3_q, rnd_p3_q, inx_p3_q;
  fp_cls_t              cls_a_p3_q, cls_b_p3_q;
  logic [MAN_W-1:0]     frac_p3_q;
  logic signed [EW-1:0] exp_p3_q;

  logic                 vld_p4_q;
  logic [W-1:0]         out_p4_q;
  logic [3:0]           flags_p4_q;

  // Unpack (combinational feed of the first register stage)
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  fp_cls_t              cls_a_d, cls_b_d;
  logic signed [EW-1:0] exp_p1_d;

  assign ea = bus.a[W-2:MAN_W];
  assign eb = bus.b[W-2:MAN_W];
  assign fa = bus.a[MAN_W-1:0];
  assign fb = bus.b[MAN_W-1:0];

  assign cls_a_d  = classify(&ea, ~|ea, fa[MAN_W-1], |fa);
  assign cls_b_d  = classify(&eb, ~|eb, fb[MAN_W-1], |fb);
  assign exp_p1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

  // Round (feed of the third register stage)
  logic [MAN_W-1:0]     frac_p3_d;
  logic signed [EW-1:0] exp_p3_d;
  logic                 inx_p3_d;

  fp_mul_round #(
    .MAN_W (MAN_W),
    .EW    (EW)
  ) u_round (
    .prod_i    (prod_p2_q),
    .exp_i     (exp_p2_q),
    .rne_i     (rnd_p2_q == RND_RNE),
    .frac_o    (frac_p3_d),
    .exp_o     (exp_p3_d),
    .inexact_o (inx_p3_d)
  );

  // Pack (feed of the output register stage)
  logic [W+3:0] pack_d;
  assign pack_d = pack_result(sgn_p3_q, cls_a_p3_q, cls_b_p3_q, frac_p3_q,
                              exp_p3_q, inx_p3_q, rnd_p3_q);

  assign stall        = vld_p4_q && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      sgn_p1_q   <= 1'b0;
      rnd_p1_q   <= 1'b0;
      cls_a_p1_q <= '0;
      cls_b_p1_q <= '0;
      man_a_p1_q <= '0;
      man_b_p1_q <= '0;
      exp_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      sgn_p2_q   <= 1'b0;
      rnd_p2_q   <= 1'b0;
      cls_a_p2_q <= '0;
      cls_b_p2_q <= '0;
      prod_p2_q  <= '0;
      exp_p2_q   <= '0;
      vld_p3_q   <= 1'b0;
      sgn_p3_q   <= 1'b0;
      rnd_p3_q   <= 1'b0;
      inx_p3_q   <= 1'b0;
      cls_a_p3_q <= '0;
      cls_b_p3_q <= '0;
      frac_p3_q  <= '0;
      exp_p3_q   <= '0;
      vld_p4_q   <= 1'b0;
      out_p4_q   <= '0;
      flags_p4_q <= '0;
    end else if (en) begin
      // ---- stage 1: unpack ----
      vld_p1_q   <= bus.in_valid;
      sgn_p1_q   <= bus.a[W-1] ^ bus.b[W-1];
      rnd_p1_q   <= bus.rnd_mode;
      cls_a_p1_q <= cls_a_d;
      cls_b_p1_q <= cls_b_d;
      man_a_p1_q <= {1'b1, fa};
      man_b_p1_q <= {1'b1, fb};
      exp_p1_q   <= exp_p1_d;
      // ---- stage 2: multiply ----
      vld_p2_q   <= vld_p1_q;
      sgn_p2_q   <= sgn_p1_q;
      rnd_p2_q   <= rnd_p1_q;
      cls_a_p2_q <= cls_a_p1_q;
      cls_b_p2_q <= cls_b_p1_q;
      prod_p2_q  <= PW'(man_a_p1_q) * PW'(man_b_p1_q);
      exp_p2_q   <= exp_p1_q;
      // ---- stage 3: normalise / round ----
      vld_p3_q   <= vld_p2_q;
      sgn_p3_q   <= sgn_p2_q;
      rnd_p3_q   <= rnd_p2_q;
      inx_p3_q   <= inx_p3_d;
      cls_a_p3_q <= cls_a_p2_q;
      cls_b_p3_q <= cls_b_p2_q;
      frac_p3_q  <= frac_p3_d;
      exp_p3_q   <= exp_p3_d;
      // ---- stage 4: pack / exceptions ----
      vld_p4_q   <= vld_p3_q;
      out_p4_q   <= pack_d[W-1:0];
      flags_p4_q <= pack_d[W+3:W];
    end
  end

  assign bus.out_valid = vld_p4_q;
  assign bus.out       = out_p4_q;
  assign bus.flags     = flags_p4_q;

endmodule

// File: tb/tb_fp_mult_pipe_hs.sv
// Self-checking bench for fp_mult_pipe_hs (FP32 defaults): directed
// vectors, back-pressure, reset with work in flight and a randomized
// stream scored against a behavioural model.
module tb_fp_mult_pipe_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mult_pipe_hs_if bus ();

  fp_mult_pipe_hs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  bit saw_stall = 1'b0;
  bit rand_done = 1'b0;
  logic [35:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic rm);
    logic sgn;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, infz, inx;
    longint unsigned p, q, rem, half;
    int e, sh;
    sgn = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    a_nan = (ea == 8'hFF) && (fa != 0); b_nan = (eb == 8'hFF) && (fb != 0);
    a_snan = a_nan && !fa[22]; b_snan = b_nan && !fb[22];
    a_inf = (ea == 8'hFF) && (fa == 0); b_inf = (eb == 8'hFF) && (fb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    infz = (a_inf && b_zero) || (a_zero && b_inf);
    if (a_nan || b_nan || infz) return {(a_snan || b_snan || infz), 3'b000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, sgn, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {4'b0000, sgn, 31'h0};
    p = (64'(fa) | (64'd1 << 23)) * (64'(fb) | (64'd1 << 23));
    e = int'(ea) + int'(eb) - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx = (rem != 0);
    if (!rm && ((rem > half) || ((rem == half) && q[0]))) q++;
    if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e++; end
    if (e >= 255) return {4'b0101, rm ? {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'h0}};
    if (e <= 0) return {4'b0011, sgn, 31'h0};
    return {3'b000, inx, sgn, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom());
    if ($urandom_range(0, 3) == 0) f = f & 23'h00000F;
    case ($urandom_range(0, 9))
      0: e = 8'h00;
      1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      2: e = 8'($urandom_range(190, 254));
      3: e = 8'($urandom_range(1, 70));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!bus.in_ready) saw_stall = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("stale_out_valid", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_out", bus.out, e[31:0]);
          check_eq("sb_flags", bus.flags, e[35:32]);
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.rnd_mode));
    end
  end

  // Present one operand pair and hold it until the transfer edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic rm);
    bit ok;
    int k;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.rnd_mode = rm;
    ok = 1'b0; k = 0;
    while (!ok && k < 200) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
      k++;
    end
    if (!ok) check_eq("send_timeout", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic rm, input logic [31:0] eo, input logic [3:0] ef);
    int n;
    send(a, b, rm);
    n = 1;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_lat"}, n, 4);
    check_eq({tag, "_out"}, bus.out, eo);
    check_eq({tag, "_flags"}, bus.flags, ef);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.rnd_mode = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out", bus.out, 32'h0);
    check_eq("rst_flags", bus.flags, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("in_ready_after_rst", bus.in_ready, 1'b1);

    run_dir("basic",     32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_dir("tie_rne",   32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001);
    run_dir("tie_rtz",   32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'b0001);
    run_dir("ovf_rne",   32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101);
    run_dir("ovf_rtz",   32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101);
    run_dir("inf_zero",  32'h7F800000, 32'h80000000, 1'b0, 32'h7FC00000, 4'b1000);
    run_dir("snan",      32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_dir("underflow", 32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011);
    run_dir("neg_inf",   32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000);

    // Back-pressure mid-stream
    n0 = n_out; saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({2'b00, 7'($urandom_range(0, 127)), 23'($urandom())}, 32'h3FC00000, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check_eq("bp_count", n_out - n0, 8);
    check_eq("bp_in_ready_fell", saw_stall, 1'b1);

    // Reset with three operations in flight
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h40400000, 32'h40400000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_out_valid", bus.out_valid, 1'b0);
    check_eq("midrst_out", bus.out, 32'h0);
    check_eq("midrst_flags", bus.flags, 4'h0);
    rst = 1'b0;
    n0 = n_out;
    repeat (10) @(posedge clk);
    #1;
    check_eq("midrst_no_stale", n_out - n0, 0);

    // Randomized stream with random back-pressure
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain("rand_drain");
    check_eq("rand_count", n_out - n0, 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
